// File: rtl/rsa_pkg.sv
// rsa_pkg: shared select codes, FSM state encoding and default width for the RSA exponent controller
package rsa_pkg;
  localparam int W_DEF = 256;
  localparam logic [1:0] SEL_RES = 2'd0;
  localparam logic [1:0] SEL_BASE = 2'd1;
  localparam logic [1:0] SEL_MSG = 2'd2;
  localparam logic [1:0] SEL_MOD = 2'd3;
  typedef enum logic [2:0] {IDLE, INIT, MUL_REQ, MUL_WAIT, SQR_REQ, SQR_WAIT, DONE} state_t;
endpackage

// File: rtl/rsa_exp_ctrl_if.sv
// rsa_exp_ctrl_if: host and multiplier handshake bundle of the exponent controller
interface rsa_exp_ctrl_if #(parameter int W = 256, parameter int CW = 9);
  logic start;
  logic [W-1:0] exp_i;
  logic abort;
  logic mm_done;
  logic mm_start;
  logic [1:0] mm_sel_a;
  logic [1:0] mm_sel_b;
  logic [1:0] mm_dst;
  logic init;
  logic busy;
  logic ready;
  logic done;
  logic [CW-1:0] op_cnt;
  modport master(output start, exp_i, abort, mm_done,
                 input mm_start, mm_sel_a, mm_sel_b, mm_dst, init, busy, ready, done, op_cnt);
  modport slave(input start, exp_i, abort, mm_done,
                output mm_start, mm_sel_a, mm_sel_b, mm_dst, init, busy, ready, done, op_cnt);
endinterface

// File: rtl/rsa_exp_shreg.sv
// rsa_exp_shreg: exponent shift register, LSB-first, with zero flags on current and shifted value
module rsa_exp_shreg #(parameter int W = 256) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic shift,
  input  logic [W-1:0] d,
  output logic bit0,
  output logic zero,
  output logic zero_sh
);
  logic [W-1:0] e;
  assign bit0 = e[0];
  assign zero = e == '0;
  assign zero_sh = e[W-1:1] == '0;
  // load takes precedence so a fresh exponent never gets shifted on its capture cycle
  always_ff @(posedge clk or negedge reset)
    if (!reset) e <= '0;
    else if (load) e <= d;
    else if (shift) e <= e >> 1;
endmodule

// File: rtl/rsa_exp_ctrl.sv
// rsa_exp_ctrl: right-to-left square-and-multiply sequencer driving an external modular multiplier
module rsa_exp_ctrl import rsa_pkg::*; #(parameter int W = W_DEF, parameter int CW = 9) (
  input logic clk,
  input logic reset,
  rsa_exp_ctrl_if.slave bus
);
  state_t st, nxt;
  logic [CW-1:0] bcnt;
  logic bit0, zero, zero_sh, load, shift, sat, req;
  // sat flags that the next consumed bit would reach W; only a guard, legal exponents finish first
  assign sat = bcnt >= CW'(W - 1);
  assign nxt = bus.abort ? IDLE :
               st == IDLE ? (bus.start ? INIT : IDLE) :
               st == INIT ? (zero ? DONE : bit0 ? MUL_REQ : SQR_REQ) :
               st == MUL_REQ ? MUL_WAIT :
               st == SQR_REQ ? SQR_WAIT :
               st == MUL_WAIT ? (!bus.mm_done ? MUL_WAIT : (zero_sh || sat) ? DONE : SQR_REQ) :
               st == SQR_WAIT ? (!bus.mm_done ? SQR_WAIT : bit0 ? MUL_REQ : sat ? DONE : SQR_REQ) :
               IDLE;
  assign load = nxt == INIT;
  assign req = nxt == MUL_REQ || nxt == SQR_REQ;
  assign shift = !bus.abort && ((st == INIT && !zero && !bit0) ||
                 (bus.mm_done && (st == MUL_WAIT || (st == SQR_WAIT && !bit0))));
  rsa_exp_shreg #(.W(W)) u_shreg (
    .clk(clk), .reset(reset), .load(load), .shift(shift), .d(bus.exp_i),
    .bit0(bit0), .zero(zero), .zero_sh(zero_sh)
  );
  // outputs are registered from the next state so every pulse lines up with the state it belongs to
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st <= IDLE;
      bcnt <= '0;
      bus.op_cnt <= '0;
      bus.mm_start <= 1'b0;
      bus.mm_sel_a <= SEL_RES;
      bus.mm_sel_b <= SEL_RES;
      bus.mm_dst <= SEL_RES;
      bus.init <= 1'b0;
      bus.busy <= 1'b0;
      bus.ready <= 1'b1;
      bus.done <= 1'b0;
    end else begin
      st <= nxt;
      bus.mm_start <= req;
      bus.init <= nxt == INIT;
      bus.done <= nxt == DONE;
      bus.ready <= nxt == IDLE;
      bus.busy <= nxt != IDLE;
      bus.op_cnt <= load ? '0 : req ? bus.op_cnt + 1'b1 : bus.op_cnt;
      bcnt <= load ? '0 : shift ? bcnt + 1'b1 : bcnt;
      if (req) begin
        bus.mm_sel_a <= nxt == MUL_REQ ? SEL_RES : SEL_BASE;
        bus.mm_sel_b <= SEL_BASE;
        bus.mm_dst <= nxt == MUL_REQ ? SEL_RES : SEL_BASE;
      end
    end
endmodule

// File: tb/tb_rsa_exp_ctrl.sv
// tb_rsa_exp_ctrl: directed and random exponent runs against a square-and-multiply command model
module tb_rsa_exp_ctrl;
  localparam logic [5:0] CMD_MUL = 6'b00_01_00;
  localparam logic [5:0] CMD_SQR = 6'b01_01_01;
  logic clk = 1'b0;
  logic reset;
  int n_vec = 0, n_err = 0;
  int cyc = 0, due = -1, lat = 3;
  rsa_exp_ctrl_if #(.W(8), .CW(9)) bus();
  rsa_exp_ctrl #(.W(8), .CW(9)) dut(.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // multiplier model: mm_done pulses lat cycles after an observed mm_start
  task automatic tick(input bit extra);
    if (bus.mm_start) due = cyc + lat;
    bus.mm_done = (cyc == due) || extra;
    @(negedge clk);
    cyc++;
  endtask
  task automatic run(input logic [7:0] e, input int l, input bit hold, input bit spur);
    logic [5:0] q[$];
    int msb = -1, done_at = -1, inits = 0, n, budget;
    logic [8:0] ocnt;
    for (int i = 0; i < 8; i++) if (e[i]) msb = i;
    for (int i = 0; i <= msb; i++) begin
      if (e[i]) q.push_back(CMD_MUL);
      if (i < msb) q.push_back(CMD_SQR);
    end
    n = q.size();
    budget = 2 + (l + 1) * n + 20;
    lat = l;
    if (spur) begin
      ocnt = bus.op_cnt;
      tick(1'b1);
      check("idle_spur_opcnt", bus.op_cnt, ocnt);
      check("idle_spur_busy", bus.busy, 0);
    end
    bus.exp_i = e;
    for (int c = 1; c <= budget && done_at < 0; c++) begin
      if (bus.init) inits++;
      if (bus.mm_start) begin
        if (q.size() == 0) check("extra_op", 1, 0);
        else check("op_sel", {bus.mm_sel_a, bus.mm_sel_b, bus.mm_dst}, q.pop_front());
      end
      if (bus.done) begin
        done_at = c;
        check("done_busy", bus.busy, 1);
        check("done_ready", bus.ready, 0);
      end
      bus.start = (c == 1) || (hold && done_at < 0);
      tick(spur && bus.mm_start);
    end
    bus.start = 1'b0;
    check("done_latency", done_at, 2 + (l + 1) * n + 1);
    check("op_cnt", bus.op_cnt, n);
    check("ops_left", q.size(), 0);
    check("init_pulses", inits, 1);
    check("after_ready", bus.ready, 1);
    check("after_busy", bus.busy, 0);
    check("after_done", bus.done, 0);
  endtask
  initial begin
    int k;
    reset = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.mm_done = 1'b0;
    bus.exp_i = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", bus.ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_outs", {bus.done, bus.mm_start, bus.init, bus.mm_sel_a, bus.mm_sel_b, bus.mm_dst}, 0);
    check("rst_opcnt", bus.op_cnt, 0);
    reset = 1'b1;
    tick(1'b0);
    run(8'd5, 3, 1'b0, 1'b0);
    run(8'd0, 3, 1'b0, 1'b0);
    run(8'h80, 3, 1'b0, 1'b0);
    run(8'hFF, 2, 1'b0, 1'b0);
    run(8'd5, 3, 1'b1, 1'b1);
    run(8'd6, 1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) run(8'($urandom_range(1, 255)), $urandom_range(1, 4), 1'($urandom_range(0, 1)), 1'b0);
    lat = 3;
    k = 0;
    bus.exp_i = 8'd5;
    bus.start = 1'b1;
    tick(1'b0);
    bus.start = 1'b0;
    for (int c = 0; c < 40 && k < 2; c++) begin
      if (bus.mm_start) k++;
      tick(1'b0);
    end
    check("abort_reach_sqr", k, 2);
    bus.abort = 1'b1;
    tick(1'b0);
    bus.abort = 1'b0;
    check("abort_ready", bus.ready, 1);
    check("abort_busy", bus.busy, 0);
    check("abort_pulses", {bus.mm_start, bus.done}, 0);
    check("abort_opcnt", bus.op_cnt, 2);
    for (int c = 0; c < 6; c++) begin
      tick(1'b0);
      check("late_done_quiet", {bus.mm_start, bus.done, bus.ready, bus.op_cnt}, {2'b00, 1'b1, 9'd2});
    end
    run(8'd3, 3, 1'b0, 1'b0);
    bus.exp_i = 8'h0B;
    bus.start = 1'b1;
    tick(1'b0);
    bus.start = 1'b0;
    for (int c = 0; c < 10 && !bus.mm_start; c++) tick(1'b0);
    tick(1'b0);
    check("pre_rst_busy", bus.busy, 1);
    check("pre_rst_opcnt", bus.op_cnt, 1);
    #1 reset = 1'b0;
    #1;
    check("async_rst_ready", bus.ready, 1);
    check("async_rst_busy", bus.busy, 0);
    check("async_rst_outs", {bus.done, bus.mm_start, bus.init, bus.mm_sel_a, bus.mm_sel_b, bus.mm_dst}, 0);
    check("async_rst_opcnt", bus.op_cnt, 0);
    @(negedge clk);
    reset = 1'b1;
    tick(1'b0);
    check("post_rst_ready", bus.ready, 1);
    check("post_rst_busy", bus.busy, 0);
    run(8'd9, 2, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
